// File: rtl/fsm_seq_pkg.sv
// ---------------------------------------------------------------------------
// Package: fsm_seq_pkg
// Shared types, default sizes and helpers for the ring sequencer slice.
//   ctrl_state_e   : controller state (IDLE, DWELL, STEP, WAIT), 2 bits
//   *_DEF          : default ring length, state width and dwell width
//   ringNext()     : successor of a ring state, wrapping to 0 after the last
// ---------------------------------------------------------------------------
package fsm_seq_pkg;

    localparam int NUM_STATES_DEF = 9;
    localparam int ST_W_DEF       = 4;
    localparam int DWELL_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2,
        WAIT  = 2'd3
    } ctrl_state_e;

    // Successor of ring state cur in a ring of num states. Anything at or past
    // the last legal state wraps back to 0, so a corrupted index cannot run off.
    function automatic int unsigned ringNext(input int unsigned cur,
                                             input int unsigned num);
        if (cur >= num - 32'd1) begin
            return 32'd0;
        end
        return cur + 32'd1;
    endfunction

endpackage

// File: rtl/fsm_dwell_table.sv
// ---------------------------------------------------------------------------
// Module: fsm_dwell_table
// Per-state dwell register file for the ring sequencer.
// NUM_STATES entries of DWELL_W bits, one synchronous write port and one
// asynchronous read port. All entries clear to 0 on reset.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   wr_en    in   write strobe
//   wr_addr  in   write index; indices >= NUM_STATES are dropped
//   wr_data  in   dwell value to store
//   rd_addr  in   read index; indices >= NUM_STATES read as 0
//   rd_data  out  dwell value at rd_addr (combinational)
// ---------------------------------------------------------------------------
module fsm_dwell_table
    import fsm_seq_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF,
    parameter int ST_W       = ST_W_DEF,
    parameter int DWELL_W    = DWELL_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ST_W-1:0]    wr_addr,
    input  logic [DWELL_W-1:0] wr_data,
    input  logic [ST_W-1:0]    rd_addr,
    output logic [DWELL_W-1:0] rd_data
);

    logic [DWELL_W-1:0] mem_q [NUM_STATES];

    // Storage. Because the read port is combinational off these registers, a
    // write and a read of the same entry in one cycle returns the old value;
    // the new value is seen from the following cycle onward.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && (32'(wr_addr) < NUM_STATES)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port, guarded so an out-of-range index never reaches the array.
    always_comb begin
        rd_data = '0;
        if (32'(rd_addr) < NUM_STATES) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Module: fsm_seq_ctrl
// Sequencer for a NUM_STATES-state ring datapath. Holds each ring state for a
// programmable dwell D (D+3 cycles per state), then issues a single-cycle
// advance pulse (adv one-hot + en) and checks that the ring reports the
// expected successor state before moving on.
// Connections: adv -> ring i0..i(N-1), en -> ring en, ring y -> st_in.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset, clears all state
//   cfg_we    in   dwell table write strobe (allowed while busy)
//   cfg_addr  in   dwell table index
//   cfg_data  in   dwell value D
//   start     in   begin a sequence (only looked at in IDLE, beats stop)
//   stop      in   abort the sequence (ignored in IDLE and STEP)
//   st_in     in   ring state reported by the datapath
//   adv       out  one-hot advance, asserted only with en
//   en        out  ring enable pulse (controller in STEP)
//   busy      out  controller not in IDLE
//   done      out  one-cycle pulse when the ring wraps back to state 0
//   err       out  sticky flag: ring mismatch or start with ring not at 0
// Build option:
//   SEQ_CTRL_LOOP_EN  defined   -> keep cycling passes until stop
//                     undefined -> single pass, return to IDLE on wrap
// ---------------------------------------------------------------------------
module fsm_seq_ctrl
    import fsm_seq_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF,
    parameter int ST_W       = ST_W_DEF,
    parameter int DWELL_W    = DWELL_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [ST_W-1:0]       cfg_addr,
    input  logic [DWELL_W-1:0]    cfg_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ST_W-1:0]       st_in,
    output logic [NUM_STATES-1:0] adv,
    output logic                  en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    ctrl_state_e        ctrl_q;
    logic [ST_W-1:0]    exp_q;
    logic [ST_W-1:0]    exp_d;
    logic [DWELL_W-1:0] cnt_q;
    logic               done_q;
    logic               err_q;
    logic [ST_W-1:0]    tbl_addr;
    logic [DWELL_W-1:0] tbl_data;

    // The ring state the controller expects to see after the pending advance.
    assign exp_d = ST_W'(ringNext(32'(exp_q), NUM_STATES));

    // Only two loads ever happen: entry 0 when a sequence is accepted from
    // IDLE, and the successor entry when WAIT confirms the ring has moved.
    // Every other cycle the read value is ignored, so exp_d is a safe default.
    assign tbl_addr = (ctrl_q == IDLE) ? '0 : exp_d;

    fsm_dwell_table #(
        .NUM_STATES (NUM_STATES),
        .ST_W       (ST_W),
        .DWELL_W    (DWELL_W)
    ) u_dwell_table (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (cfg_we),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (tbl_addr),
        .rd_data (tbl_data)
    );

    // Controller FSM. DWELL counts the loaded dwell down to 0 (D+1 cycles),
    // STEP issues the advance for exactly one cycle, WAIT checks the ring's
    // answer. done is cleared every cycle so it can only ever be one cycle wide.
    // stop is deliberately not looked at in STEP: the pulse is already out, so
    // the ring has moved regardless and WAIT still gets to see the result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q <= IDLE;
            exp_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (ctrl_q)
                IDLE: begin
                    if (start) begin
                        if (st_in == '0) begin
                            ctrl_q <= DWELL;
                            cnt_q  <= tbl_data;
                            exp_q  <= '0;
                            err_q  <= 1'b0;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
                DWELL: begin
                    if (stop) begin
                        ctrl_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        ctrl_q <= STEP;
                    end else begin
                        cnt_q  <= cnt_q - DWELL_W'(1);
                    end
                end
                STEP: begin
                    ctrl_q <= WAIT;
                end
                WAIT: begin
                    if (stop) begin
                        ctrl_q <= IDLE;
                    end else if (st_in != exp_d) begin
                        err_q  <= 1'b1;
                        ctrl_q <= IDLE;
                    end else begin
                        exp_q  <= exp_d;
                        cnt_q  <= tbl_data;
                        if (exp_d == '0) begin
                            done_q <= 1'b1;
`ifdef SEQ_CTRL_LOOP_EN
                            ctrl_q <= DWELL;
`else
                            ctrl_q <= IDLE;
`endif
                        end else begin
                            ctrl_q <= DWELL;
                        end
                    end
                end
                default: begin
                    ctrl_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded straight from registered state so that an asynchronous
    // reset drops adv/en immediately, without waiting for a clock edge.
    assign en   = (ctrl_q == STEP);
    assign adv  = en ? (NUM_STATES'(1) << exp_q) : '0;
    assign busy = (ctrl_q != IDLE);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench: tb_fsm_seq_ctrl
// Directed bench for fsm_seq_ctrl with a small behavioural ring model on
// st_in. Cycle indices are counted from the cycle in which start is driven
// (index 0); expected advance times come from a per-state dwell model:
//   first en at 2 + D0, each following en D_k + 3 later, done 2 after the last.
// ---------------------------------------------------------------------------
module tb_fsm_seq_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       start;
    logic       stop;
    logic [3:0] st_in;
    logic [8:0] adv;
    logic       en;
    logic       busy;
    logic       done;
    logic       err;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Ring model controls
    logic [3:0] ringState;
    logic       forceEn;
    logic [3:0] forceVal;
    int         ringStall;

    // Dwell model and run log
    int         dwellModel [9];
    int         enIdx [$];
    logic [8:0] advLog [$];
    int         doneLog [$];
    int         idleIdx;
    int         strayAdv;
    logic       errAt1;

    fsm_seq_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .stop     (stop),
        .st_in    (st_in),
        .adv      (adv),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clock = ~clock;

    // Ring datapath model: moves one state per en pulse unless stalled at
    // ringStall, and can be forced to a given state by the bench.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            ringState <= 4'd0;
        end else if (forceEn) begin
            ringState <= forceVal;
        end else if (en && (int'(ringState) != ringStall)) begin
            ringState <= (ringState == 4'd8) ? 4'd0 : ringState + 4'd1;
        end
    end

    assign st_in = forceEn ? forceVal : ringState;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int expEn(input int k);
        int e;
        e = 2 + dwellModel[0];
        for (int i = 1; i <= k; i++) begin
            e += dwellModel[i] + 3;
        end
        return e;
    endfunction

    // Start a sequence in cycle 0 and log en/adv/done until busy drops or the
    // budget runs out. stop and a single cfg write can be placed at any index.
    task automatic applyStimulus(input int budget, input int stopIdx, input int cfgIdx,
                                 input logic [3:0] cfgA, input logic [7:0] cfgD);
        int idx;
        enIdx.delete();
        advLog.delete();
        doneLog.delete();
        idleIdx  = -1;
        strayAdv = 0;
        errAt1   = 1'bx;
        idx      = 0;
        start    = 1'b1;
        stop     = (stopIdx == 0);
        cfg_we   = (cfgIdx == 0);
        cfg_addr = cfgA;
        cfg_data = cfgD;
        while (idleIdx < 0 && idx < budget) begin
            tick();
            idx++;
            if (en) begin
                enIdx.push_back(idx);
                advLog.push_back(adv);
            end else if (adv != 9'd0) begin
                strayAdv++;
            end
            if (done) doneLog.push_back(idx);
            if (idx == 1) errAt1 = err;
            if (!busy) idleIdx = idx;
            start  = 1'b0;
            stop   = (idx == stopIdx);
            cfg_we = (idx == cfgIdx);
        end
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
        checkOutput("run_terminates", int'(idleIdx >= 0), 1);
    endtask

    task automatic checkRun(input string tag, input int nPulses, input int expDone, input int expIdle);
        checkOutput($sformatf("%s_pulses", tag), enIdx.size(), nPulses);
        for (int k = 0; k < nPulses; k++) begin
            checkOutput($sformatf("%s_en%0d", tag, k),
                        (k < enIdx.size()) ? enIdx[k] : -1, expEn(k));
            checkOutput($sformatf("%s_adv%0d", tag, k),
                        (k < advLog.size()) ? int'(advLog[k]) : -1, 1 << k);
        end
        checkOutput($sformatf("%s_doneCount", tag), doneLog.size(), (expDone >= 0) ? 1 : 0);
        checkOutput($sformatf("%s_doneAt", tag), (doneLog.size() > 0) ? doneLog[0] : -1, expDone);
        checkOutput($sformatf("%s_idleAt", tag), idleIdx, expIdle);
        checkOutput($sformatf("%s_strayAdv", tag), strayAdv, 0);
    endtask

    initial begin
        int enSeen;
        reset     = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 4'd0;
        cfg_data  = 8'd0;
        start     = 1'b0;
        stop      = 1'b0;
        forceEn   = 1'b0;
        forceVal  = 4'd0;
        ringStall = -1;
        for (int i = 0; i < 9; i++) dwellModel[i] = 0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_adv", int'(adv), 0);
        checkOutput("rst_en", int'(en), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'(err), 0);
        reset = 1'b0;
        tick();

        // 1: all-zero table, full single pass of 27 cycles
        $display("[TB] test 1: zero dwell pass");
        applyStimulus(60, -1, -1, 4'd0, 8'd0);
        checkRun("t1", 9, 28, 28);
        checkOutput("t1_errAt1", int'(errAt1), 0);
        tick();
        checkOutput("t1_doneOneCycle", int'(done), 0);
        checkOutput("t1_busyAfter", int'(busy), 0);

        // 2: table[3]=5 stretches state 3 to 8 cycles
        $display("[TB] test 2: long dwell on state 3");
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 8'd5;
        tick();
        cfg_we = 1'b0;
        dwellModel[3] = 5;
        applyStimulus(80, -1, -1, 4'd0, 8'd0);
        checkRun("t2", 9, 33, 33);

        // 3: ring refuses to leave state 2 -> err, back to IDLE
        $display("[TB] test 3: ring mismatch");
        ringStall = 2;
        applyStimulus(40, -1, -1, 4'd0, 8'd0);
        checkRun("t3", 3, -1, 10);
        checkOutput("t3_err", int'(err), 1);
        checkOutput("t3_en", int'(en), 0);
        checkOutput("t3_adv", int'(adv), 0);
        enSeen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (en || adv != 9'd0) enSeen++;
        end
        checkOutput("t3_quietAfter", enSeen, 0);
        checkOutput("t3_errSticky", int'(err), 1);

        // 4: illegal start with ring at 4, then legal start together with stop
        $display("[TB] test 4: illegal start then restart");
        ringStall = -1;
        forceEn = 1'b1; forceVal = 4'd4;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("t4_errIllegal", int'(err), 1);
        checkOutput("t4_busyIllegal", int'(busy), 0);
        forceVal = 4'd0;
        tick();
        forceEn = 1'b0;
        applyStimulus(80, 0, -1, 4'd0, 8'd0);
        checkOutput("t4_errCleared", int'(errAt1), 0);
        checkRun("t4", 9, 33, 33);

        // 5: table[6]=2; write table[1]=4 in the same cycle it is loaded (old
        // value used); stop in the middle of state 6's dwell
        $display("[TB] test 5: stop in dwell, write during load");
        cfg_we = 1'b1; cfg_addr = 4'd6; cfg_data = 8'd2;
        tick();
        cfg_we = 1'b0;
        dwellModel[6] = 2;
        applyStimulus(80, 25, 3, 4'd1, 8'd4);
        checkRun("t5", 6, -1, 26);
        enSeen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (en) enSeen++;
        end
        checkOutput("t5_noEnAfterStop", enSeen, 0);

        // 5b: new table[1]=4 now in effect; reset asserted during STEP
        $display("[TB] test 5b: reset during step");
        dwellModel[1] = 4;
        forceEn = 1'b1; forceVal = 4'd0;
        tick();
        forceEn = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("t5b_adv0", int'(adv), 1);
        repeat (7) tick();
        checkOutput("t5b_adv1", int'(adv), 2);
        checkOutput("t5b_en1", int'(en), 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("t5b_asyncAdv", int'(adv), 0);
        checkOutput("t5b_asyncEn", int'(en), 0);
        checkOutput("t5b_asyncBusy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) dwellModel[i] = 0;
        applyStimulus(60, -1, -1, 4'd0, 8'd0);
        checkRun("t5c", 9, 28, 28);

`ifdef SEQ_CTRL_LOOP_EN
        // 6: continuous passes until stop
        $display("[TB] test 6: loop mode");
        applyStimulus(90, 60, -1, 4'd0, 8'd0);
        checkOutput("t6_doneCount", doneLog.size(), 2);
        checkOutput("t6_done0", (doneLog.size() > 0) ? doneLog[0] : -1, 28);
        checkOutput("t6_done1", (doneLog.size() > 1) ? doneLog[1] : -1, 55);
        checkOutput("t6_idleAt", idleIdx, 61);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
